// File: rtl/inst_fetch_queue_if.sv
// Handshake bundle around the instruction fetch queue: PC-stage address input,
// instruction-memory request/response, flush, and the decode-side output.
interface inst_fetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] addr_in;
  logic              addr_valid;
  logic              addr_ready;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;
  logic              flush;
  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;

  // queue side
  modport slave (
    input  addr_in, addr_valid, mem_req_ready, mem_rsp_valid, mem_rsp_data,
           flush, inst_ready,
    output addr_ready, mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc
  );

  // environment side (PC stage, memory, decode)
  modport master (
    output addr_in, addr_valid, mem_req_ready, mem_rsp_valid, mem_rsp_data,
           flush, inst_ready,
    input  addr_ready, mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// In-order instruction fetch queue: allocates a ring slot per issued request,
// fills slots from in-order memory responses, and pops {pc, data} to decode.
module inst_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  inst_fetch_queue_if.slave fq
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0]     wr_q, wr_d, fill_q, fill_d, rd_q, rd_d, drop_q, drop_d;
  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [ADDR_W-1:0] pc_d   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]  filled_q, filled_d;

  logic [IW-1:0] wr_idx_s, fill_idx_s, rd_idx_s;
  logic [PW-1:0] occ_s;
  logic [PW:0]   credit_sum_s;
  logic          credit_ok_s, fire_s, pop_s, inst_valid_s;

  assign wr_idx_s     = wr_q[IW-1:0];
  assign fill_idx_s   = fill_q[IW-1:0];
  assign rd_idx_s     = rd_q[IW-1:0];
  assign occ_s        = wr_q - rd_q;
  // outstanding-but-dropped responses still hold memory credit after a flush
  assign credit_sum_s = {1'b0, occ_s} + {1'b0, drop_q};
  assign credit_ok_s  = (credit_sum_s < (PW+1)'(DEPTH));

  assign fq.mem_req_valid = fq.addr_valid & credit_ok_s & ~fq.flush;
  assign fq.addr_ready    = fq.mem_req_ready & credit_ok_s & ~fq.flush;
  assign fq.mem_req_addr  = fq.addr_in;

  assign inst_valid_s  = filled_q[rd_idx_s] & ((rd_q != fill_q) | filled_q[rd_idx_s]);
  assign fq.inst_valid = inst_valid_s;
  assign fq.inst_data  = data_q[rd_idx_s];
  assign fq.inst_pc    = pc_q[rd_idx_s];

  assign fire_s = fq.addr_valid & fq.addr_ready;
  assign pop_s  = inst_valid_s & fq.inst_ready & ~fq.flush;

  // next-state for pointers, drop counter and ring slots
  always_comb begin
    wr_d     = wr_q;
    fill_d   = fill_q;
    rd_d     = rd_q;
    drop_d   = drop_q;
    pc_d     = pc_q;
    data_d   = data_q;
    filled_d = filled_q;
    if (fq.flush) begin
      wr_d     = wr_q;
      fill_d   = wr_q;
      rd_d     = wr_q;
      filled_d = '0;
      drop_d   = drop_q + (wr_q - fill_q) - (fq.mem_rsp_valid ? PW'(1) : PW'(0));
    end else begin
      if (fire_s) begin
        pc_d[wr_idx_s]     = fq.addr_in;
        filled_d[wr_idx_s] = 1'b0;
        wr_d               = wr_q + PW'(1);
      end else begin
        wr_d = wr_q;
      end
      if (fq.mem_rsp_valid && (drop_q != PW'(0))) begin
        drop_d = drop_q - PW'(1);
      end else if (fq.mem_rsp_valid) begin
        data_d[fill_idx_s]   = fq.mem_rsp_data;
        filled_d[fill_idx_s] = 1'b1;
        fill_d               = fill_q + PW'(1);
      end else begin
        fill_d = fill_q;
      end
      if (pop_s) begin
        filled_d[rd_idx_s] = 1'b0;
        rd_d               = rd_q + PW'(1);
      end else begin
        rd_d = rd_q;
      end
    end
  end

  // state registers, cleared asynchronously by rst_n
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q     <= '0;
      fill_q   <= '0;
      rd_q     <= '0;
      drop_q   <= '0;
      filled_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      wr_q     <= wr_d;
      fill_q   <= fill_d;
      rd_q     <= rd_d;
      drop_q   <= drop_d;
      filled_q <= filled_d;
      pc_q     <= pc_d;
      data_q   <= data_d;
    end
  end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with a latency-programmable memory model
// and a decode-side monitor logging every pop.
module tb_inst_fetch_queue;
  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   mem_lat = 1;
  int   req_cnt = 0;
  bit   toggle_en = 1'b0;
  logic [31:0] pend_a [$];
  int          pend_t [$];
  logic [31:0] log_pc [$];

  inst_fetch_queue_if #(.ADDR_W(32), .DATA_W(32)) fq ();

  inst_fetch_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fq    (fq.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'h5EED_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // present one address and hold it until accepted; returns at +1 after the firing edge
  task automatic send(input logic [31:0] a);
    int n;
    n = 0;
    fq.addr_in    = a;
    fq.addr_valid = 1'b1;
    #1;
    while (!fq.addr_ready && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 100) chk("send_timeout", 32'h0, 32'h1);
    @(posedge clk);
    #1;
    fq.addr_valid = 1'b0;
  endtask

  task automatic wait_log(input int n);
    int k;
    k = 0;
    while (log_pc.size() < n && k < 100) begin
      step();
      k++;
    end
    chk("log_count", 32'(log_pc.size()), 32'(n));
  endtask

  // memory: in-order responses mem_lat cycles after acceptance, cleared by reset
  initial begin
    fq.mem_rsp_valid = 1'b0;
    fq.mem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend_a.delete();
        pend_t.delete();
        fq.mem_rsp_valid = 1'b0;
        fq.mem_rsp_data  = '0;
      end else begin
        if (fq.mem_req_valid && fq.mem_req_ready) begin
          pend_a.push_back(fq.mem_req_addr);
          pend_t.push_back(cyc + mem_lat);
          req_cnt++;
        end
        if (pend_a.size() > 0 && pend_t[0] <= cyc) begin
          fq.mem_rsp_valid = 1'b1;
          fq.mem_rsp_data  = mdata(pend_a.pop_front());
          void'(pend_t.pop_front());
        end else begin
          fq.mem_rsp_valid = 1'b0;
          fq.mem_rsp_data  = '0;
        end
      end
    end
  end

  // decode monitor: every effective pop must carry its own instruction word
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && fq.inst_valid && fq.inst_ready && !fq.flush) begin
        log_pc.push_back(fq.inst_pc);
        chk("pop_data", fq.inst_data, mdata(fq.inst_pc));
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (toggle_en) fq.mem_req_ready = ~fq.mem_req_ready;
    end
  end

  initial begin
    int base;
    int c0;
    int pop_cyc [$];
    rst_n            = 1'b0;
    fq.addr_in       = '0;
    fq.addr_valid    = 1'b0;
    fq.mem_req_ready = 1'b1;
    fq.flush         = 1'b0;
    fq.inst_ready    = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_inst_valid", 32'(fq.inst_valid), 32'h0);
    chk("rst_inst_pc", fq.inst_pc, 32'h0);
    chk("rst_inst_data", fq.inst_data, 32'h0);
    rst_n = 1'b1;
    step();
    chk("idle_addr_ready", 32'(fq.addr_ready), 32'h1);
    chk("idle_req_valid", 32'(fq.mem_req_valid), 32'h0);

    // reset mid-stream with three queued instructions
    mem_lat = 1;
    send(32'h10);
    send(32'h14);
    send(32'h18);
    repeat (4) step();
    chk("queued_valid", 32'(fq.inst_valid), 32'h1);
    chk("queued_pc", fq.inst_pc, 32'h10);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(fq.inst_valid), 32'h0);
    chk("midrst_pc", fq.inst_pc, 32'h0);
    step();
    step();
    rst_n = 1'b1;
    fq.inst_ready = 1'b1;
    repeat (4) step();
    chk("postrst_pops", 32'(log_pc.size()), 32'h0);
    chk("postrst_valid", 32'(fq.inst_valid), 32'h0);

    // streaming at latency 1, one instruction per cycle
    base = log_pc.size();
    send(32'h0);
    send(32'h4);
    send(32'h8);
    send(32'hC);
    c0 = 0;
    while (log_pc.size() < base + 4 && c0 < 50) begin
      @(negedge clk);
      #1;
      if (log_pc.size() > base + pop_cyc.size()) pop_cyc.push_back(cyc);
      c0++;
    end
    wait_log(base + 4);
    for (int i = 0; i < 4; i++) chk("stream_pc", log_pc[base+i], 32'(4 * i));
    for (int i = 1; i < pop_cyc.size(); i++)
      chk("stream_rate", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'h1);
    step();

    // full ring: fifth address stalls until one pop
    fq.inst_ready = 1'b0;
    base = log_pc.size();
    send(32'h20);
    send(32'h24);
    send(32'h28);
    send(32'h2C);
    fq.addr_in    = 32'h30;
    fq.addr_valid = 1'b1;
    step();
    step();
    #1;
    chk("full_addr_ready", 32'(fq.addr_ready), 32'h0);
    chk("full_req_valid", 32'(fq.mem_req_valid), 32'h0);
    chk("full_head_pc", fq.inst_pc, 32'h20);
    fq.inst_ready = 1'b1;
    step();
    fq.inst_ready = 1'b0;
    #1;
    chk("afterpop_addr_ready", 32'(fq.addr_ready), 32'h1);
    step();
    fq.addr_valid = 1'b0;
    fq.inst_ready = 1'b1;
    wait_log(base + 5);
    for (int i = 0; i < 5; i++) chk("full_order", log_pc[base+i], 32'h20 + 32'(4 * i));

    // flush with three requests in flight at latency 3
    mem_lat = 3;
    base = log_pc.size();
    send(32'h40);
    send(32'h44);
    send(32'h48);
    fq.flush = 1'b1;
    #1;
    chk("flush_addr_ready", 32'(fq.addr_ready), 32'h0);
    step();
    fq.flush = 1'b0;
    send(32'h100);
    wait_log(base + 1);
    chk("flush_new_pc", log_pc[base], 32'h100);
    repeat (8) step();
    chk("flush_no_stale", 32'(log_pc.size()), 32'(base + 1));

    // flush coinciding with a response and a would-be pop
    mem_lat = 1;
    base = log_pc.size();
    send(32'h200);
    send(32'h204);
    fq.flush = 1'b1;
    #1;
    chk("fl2_valid_in_flush", 32'(fq.inst_valid), 32'h1);
    chk("fl2_head_pc", fq.inst_pc, 32'h200);
    step();
    fq.flush = 1'b0;
    #1;
    chk("fl2_cleared", 32'(fq.inst_valid), 32'h0);
    send(32'h300);
    wait_log(base + 1);
    chk("fl2_new_pc", log_pc[base], 32'h300);
    repeat (6) step();
    chk("fl2_no_stale", 32'(log_pc.size()), 32'(base + 1));

    // memory backpressure toggling every cycle
    mem_lat = 2;
    base = log_pc.size();
    c0 = req_cnt;
    toggle_en = 1'b1;
    for (int i = 0; i < 8; i++) send(32'h400 + 32'(4 * i));
    toggle_en = 1'b0;
    fq.mem_req_ready = 1'b1;
    wait_log(base + 8);
    for (int i = 0; i < 8; i++) chk("bp_order", log_pc[base+i], 32'h400 + 32'(4 * i));
    chk("bp_req_count", 32'(req_cnt - c0), 32'h8);
    repeat (6) step();
    chk("bp_no_dup", 32'(log_pc.size()), 32'(base + 8));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
